// File: rtl/clock_ui_pkg.sv
// Shared constants and types for the clock/date display UI front end.
package clock_ui_pkg;

  localparam int unsigned CLOCK_FREQ          = 10_000_000;
  localparam int unsigned TICK_DIV_DEFAULT    = CLOCK_FREQ / 1000;
  localparam logic [7:0]  REPEAT_MASK_DEFAULT = 8'b0111_1110;
  localparam int unsigned BTN_COUNT           = 8;

  localparam int unsigned BTN_FMT12 = 0;
  localparam int unsigned BTN_UP1   = 1;
  localparam int unsigned BTN_DN1   = 2;
  localparam int unsigned BTN_UP2   = 3;
  localparam int unsigned BTN_DN2   = 4;
  localparam int unsigned BTN_UP3   = 5;
  localparam int unsigned BTN_DN3   = 6;
  localparam int unsigned BTN_DATE  = 7;

  typedef enum logic {
    REP_FIRST = 1'b0,
    REP_NEXT  = 1'b1
  } rep_phase_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button bit: 2-flop sync, tick-based debounce, press pulse and auto-repeat.
// state     | meaning
// REP_FIRST | held, waiting REPEAT_DELAY ticks for first repeat (also idle)
// REP_NEXT  | held, repeating every REPEAT_RATE ticks
module button_channel
  import clock_ui_pkg::*;
#(
  parameter int unsigned DB_TICKS     = 8,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned DBW = $clog2(DB_TICKS) + 1;
  localparam int unsigned RW  = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE)) + 1;
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_TICKS - 1);
  localparam logic [RW-1:0]  DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [1:0]     r_sync;
  logic [DBW-1:0] r_db_cnt;
  logic           r_level;
  logic           r_press;
  logic [RW-1:0]  r_rep_cnt;
  rep_phase_e     r_phase;

  logic          w_sync;
  logic          w_flip;
  logic          w_rise;
  logic          w_fall;
  logic          w_rep_fire;
  logic [RW-1:0] w_rep_last;

  assign w_sync     = r_sync[1];
  assign w_flip     = i_tick && (w_sync != r_level) && (r_db_cnt == DB_LAST);
  assign w_rise     = w_flip && w_sync;
  assign w_fall     = w_flip && !w_sync;
  assign w_rep_last = (r_phase == REP_FIRST) ? DELAY_LAST : RATE_LAST;
  // A tick that flips the level never also fires a repeat.
  assign w_rep_fire = REPEAT_EN && i_tick && r_level && !w_flip && (r_rep_cnt == w_rep_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= '0;
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_rep_cnt <= '0;
      r_phase   <= REP_FIRST;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_press <= w_rise || w_rep_fire;

      if (i_tick) begin
        if (w_sync == r_level) begin
          r_db_cnt <= '0;
        end else if (w_flip) begin
          r_level  <= w_sync;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end

      if (!r_level || w_fall) begin
        r_rep_cnt <= '0;
        r_phase   <= REP_FIRST;
      end else if (w_rep_fire) begin
        r_rep_cnt <= '0;
        r_phase   <= REP_NEXT;
      end else if (i_tick && REPEAT_EN) begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw button bus into debounced levels and press/repeat pulses.
// The sample-tick prescaler is shared by all eight channels.
module button_conditioner
  import clock_ui_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEFAULT,
  parameter int unsigned DB_TICKS     = 8,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter logic [7:0]  REPEAT_MASK  = REPEAT_MASK_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BTN_COUNT-1:0] btn_raw,
  output logic [BTN_COUNT-1:0] btn_level,
  output logic [BTN_COUNT-1:0] btn_press,
  output logic                 tick
);

  localparam int unsigned     PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic          r_tick;
  logic          w_tick_en;

  // Channels act on the same edge that raises the tick output.
  assign w_tick_en = (r_pre == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= w_tick_en ? '0 : r_pre + 1'b1;
      r_tick <= w_tick_en;
    end
  end

  assign tick = r_tick;

  for (genvar g = 0; g < BTN_COUNT; g++) begin : g_ch
    button_channel #(
      .DB_TICKS    (DB_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_EN   (REPEAT_MASK[g])
    ) u_channel (
      .clk    (clk),
      .reset  (reset),
      .i_tick (w_tick_en),
      .i_raw  (btn_raw[g]),
      .o_level(btn_level[g]),
      .o_press(btn_press[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed scenarios with literal checks, then randomized
// button activity compared cycle by cycle against a behavioural model.
module tb_button_conditioner;

  localparam int          TICK_DIV     = 4;
  localparam int          DB_TICKS     = 3;
  localparam int          REPEAT_DELAY = 5;
  localparam int          REPEAT_RATE  = 2;
  localparam logic [7:0]  REPEAT_MASK  = 8'b0111_1110;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] btn_raw = 8'h00;
  logic [7:0] btn_level;
  logic [7:0] btn_press;
  logic       tick;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .TICK_DIV    (TICK_DIV),
    .DB_TICKS    (DB_TICKS),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .REPEAT_MASK (REPEAT_MASK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .tick     (tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t, cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Behavioural model: edges since reset, a 2-deep raw history for the
  // synchronizer delay, a run length of disagreeing samples per bit, and the
  // number of ticks a masked button has been held since its press.
  logic [7:0] m_level = '0;
  logic [7:0] m_press = '0;
  logic       m_tick  = 1'b0;
  logic [7:0] m_hist0 = '0;
  logic [7:0] m_hist1 = '0;
  int         m_k     = 0;
  int         m_streak[8] = '{default: 0};
  int         m_held[8]   = '{default: 0};
  logic [7:0] m_smp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_level = '0; m_press = '0; m_tick = 1'b0;
      m_hist0 = '0; m_hist1 = '0; m_k = 0;
      for (int b = 0; b < 8; b++) begin m_streak[b] = 0; m_held[b] = 0; end
    end else begin
      m_k++;
      m_smp   = m_hist1;
      m_hist1 = m_hist0;
      m_hist0 = btn_raw;
      m_tick  = (m_k % TICK_DIV) == 0;
      m_press = '0;
      if (m_tick) begin
        for (int b = 0; b < 8; b++) begin
          if (m_smp[b] != m_level[b]) m_streak[b]++;
          else                        m_streak[b] = 0;
          if (m_streak[b] == DB_TICKS) begin
            m_streak[b] = 0;
            m_level[b]  = ~m_level[b];
            if (m_level[b]) begin
              m_press[b] = 1'b1;
              m_held[b]  = 0;
            end
          end else if (m_level[b] && REPEAT_MASK[b]) begin
            m_held[b]++;
            if (m_held[b] == REPEAT_DELAY ||
                (m_held[b] > REPEAT_DELAY && ((m_held[b] - REPEAT_DELAY) % REPEAT_RATE) == 0))
              m_press[b] = 1'b1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    check("cmp_level", btn_level, m_level);
    check("cmp_press", btn_press, m_press);
    check("cmp_tick",  tick,      m_tick);
  end

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  int cnt;
  int probs[3] = '{6, 30, 120};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_level", btn_level, 0);
    check("rst_press", btn_press, 0);
    check("rst_tick",  tick,      0);
    reset = 1'b0;

    // 1: tick timebase
    goto(3);  check("t1_tick3", tick, 0);
    goto(4);  check("t1_tick4", tick, 1);
    goto(5);  check("t1_tick5", tick, 0);
    goto(8);  check("t1_tick8", tick, 1);

    // 2: clean press on bit 1 sampled from cycle 10
    goto(9);  btn_raw[1] = 1'b1;
    goto(19); check("t2_press19", btn_press[1], 0);
              check("t2_level19", btn_level[1], 0);
    goto(20); check("t2_press20", btn_press[1], 1);
              check("t2_level20", btn_level[1], 1);
    goto(21); check("t2_press21", btn_press[1], 0);

    // 4: auto-repeat while held, then release
    goto(36); check("t4_press36", btn_press[1], 0);
    goto(40); check("t4_press40", btn_press[1], 1);
    goto(41); check("t4_press41", btn_press[1], 0);
    goto(44); check("t4_press44", btn_press[1], 0);
    goto(48); check("t4_press48", btn_press[1], 1);
    goto(56); check("t4_press56", btn_press[1], 1);
    goto(57); btn_raw[1] = 1'b0;
    goto(64); check("t4_press64", btn_press[1], 1);
    goto(68); check("t4_level68", btn_level[1], 0);
              check("t4_press68", btn_press[1], 0);

    // 3: bounce on bit 3
    goto(77); btn_raw[3] = 1'b1;
    goto(84); check("t3_level84", btn_level[3], 0);
    goto(85); btn_raw[3] = 1'b0;
    goto(89); btn_raw[3] = 1'b1;
    goto(96); check("t3_level96", btn_level[3], 0);
              check("t3_press96", btn_press[3], 0);
    goto(100); check("t3_press100", btn_press[3], 1);
               check("t3_level100", btn_level[3], 1);
    goto(101); check("t3_press101", btn_press[3], 0);
               btn_raw[3] = 1'b0;

    // 5: unmasked bits 0 and 7 held for 20 ticks
    goto(105); btn_raw[0] = 1'b1; btn_raw[7] = 1'b1;
    goto(116); check("t5_press0", btn_press[0], 1);
               check("t5_press7", btn_press[7], 1);
    cnt = 0;
    for (int c = 117; c <= 196; c++) begin
      goto(c);
      if (btn_press[0] || btn_press[7]) cnt++;
    end
    check("t5_norepeat", cnt, 0);
    check("t5_levels", {btn_level[7], btn_level[0]}, 2'b11);
    goto(197); btn_raw[0] = 1'b0; btn_raw[7] = 1'b0;

    // 6: reset mid-repeat with bit 1 held
    goto(200); btn_raw[1] = 1'b1;
    goto(212); check("t6_press212", btn_press[1], 1);
    goto(230); check("t6_level230", btn_level[1], 1);
    #1 reset = 1'b1;
    #1;
    check("t6_async_level", btn_level, 0);
    check("t6_async_press", btn_press, 0);
    check("t6_async_tick",  tick,      0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    goto(1);  check("t6_norelease_pulse", btn_press, 0);
    goto(11); check("t6_press11", btn_press[1], 0);
    goto(12); check("t6_press12", btn_press[1], 1);
              check("t6_level12", btn_level[1], 1);

    // randomized activity at three flip rates, with occasional resets
    for (int p = 0; p < 3; p++) begin
      repeat (1500) begin
        @(negedge clk);
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, probs[p] - 1) == 0) btn_raw[b] = ~btn_raw[b];
        if ($urandom_range(0, 999) == 0) begin
          #1 reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
        end
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
